// File: rtl/ikaopll_bus_sequencer.sv
// ikaopll_bus_sequencer: queued CPU-bus write sequencer for IKAOPLL cores.
// Commands {chip, A0, data} are queued on i_EMUCLK. Each one is replayed as a
// SETUP / STROBE / HOLD / WAIT bus cycle, and the cycle only advances on
// phiM-enabled edges.
module ikaopll_bus_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_CHIPS  = 1,
    parameter int CHIPW      = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
    parameter int WR_PULSE   = 2,
    parameter int ADDR_WAIT  = 12,
    parameter int DATA_WAIT  = 84
) (
    input  logic                          i_EMUCLK,
    input  logic                          i_RST,
    input  logic                          i_phiM_PCEN_n,
    input  logic                          i_CMD_VALID,
    input  logic [CHIPW+8:0]              i_CMD,
    output logic                          o_CMD_READY,
    output logic [NUM_CHIPS-1:0]          o_CS_n,
    output logic                          o_WR_n,
    output logic                          o_A0,
    output logic [7:0]                    o_D,
    output logic                          o_D_OE,
    output logic                          o_BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   o_LEVEL
);

    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CMDW = CHIPW + 9;

    localparam logic [PTRW-1:0] PTR_ONE    = 1;
    localparam logic [PTRW:0]   LVL_ONE    = 1;
    localparam logic [PTRW:0]   LVL_FULL   = FIFO_DEPTH[PTRW:0];
    localparam logic [7:0]      PULSE_LOAD = 8'(WR_PULSE - 1);
    localparam logic [7:0]      ADDR_W8    = 8'(ADDR_WAIT);
    localparam logic [7:0]      DATA_W8    = 8'(DATA_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTRW:0]     level_q, level_d;
    logic              ready_q, ready_d;
    logic              a0_q, a0_d;
    logic [7:0]        data_q, data_d;
    logic [CHIPW-1:0]  chip_q, chip_d;
    logic [CMDW-1:0]   mem_q [FIFO_DEPTH];

    logic              phi_en;
    logic              push;
    logic              pop;
    logic              strobe;
    logic [7:0]        wait_len;
    logic [CMDW-1:0]   head;

    assign phi_en   = ~i_phiM_PCEN_n;
    // READY is registered, so a push never depends combinationally on a same-edge pop.
    assign push     = i_CMD_VALID & ready_q;
    assign pop      = phi_en & (state_q == S_IDLE) & (level_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign wait_len = a0_q ? DATA_W8 : ADDR_W8;
    assign strobe   = (state_q == S_STROBE);

    // Command storage: written on every accepted push, no reset needed.
    always_ff @(posedge i_EMUCLK) begin
        if (push) mem_q[wr_ptr_q] <= i_CMD;
    end

    // Queue pointers, occupancy and registered READY.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        ready_d = (level_d != LVL_FULL);
    end

    // Bus-cycle sequencing; every transition is gated by the phiM enable.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a0_d    = a0_q;
        data_d  = data_q;
        chip_d  = chip_q;
        if (phi_en) begin
            case (state_q)
                S_IDLE: begin
                    if (level_q != '0) begin
                        {chip_d, a0_d, data_d} = head;
                        state_d = S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt_d   = PULSE_LOAD;
                    state_d = S_STROBE;
                end
                S_STROBE: begin
                    if (cnt_q == 8'd0) state_d = S_HOLD;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                S_HOLD: begin
                    // A zero wait skips WAIT entirely so the command costs exactly pulse+3.
                    if (wait_len == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = wait_len - 8'd1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 8'd0) state_d = S_IDLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and control registers with synchronous active-high reset.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
            a0_q     <= 1'b0;
            data_q   <= 8'h00;
            chip_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            a0_q     <= a0_d;
            data_q   <= data_d;
            chip_q   <= chip_d;
        end
    end

    // Chip selects decoded from state; an out-of-range chip index selects nobody.
    always_comb begin
        o_CS_n = '1;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            o_CS_n[i] = ~(strobe & (chip_q == CHIPW'(i)));
        end
    end

    assign o_WR_n      = ~strobe;
    assign o_A0        = a0_q;
    assign o_D         = data_q;
    assign o_D_OE      = (state_q == S_SETUP) | (state_q == S_STROBE) | (state_q == S_HOLD);
    assign o_BUSY      = (state_q != S_IDLE) | (level_q != '0);
    assign o_LEVEL     = level_q;
    assign o_CMD_READY = ready_q;

endmodule

// File: tb/tb_ikaopll_bus_sequencer.sv
// Testbench for ikaopll_bus_sequencer: FIFO_DEPTH=4, three chips, default timing.
// A behavioural model tracks the queue contents and each command's position
// within its bus cycle. The DUT outputs are compared with the model every
// cycle, alongside scenario checks against fixed constants.
module tb_ikaopll_bus_sequencer;

    localparam int FD = 4;
    localparam int NC = 3;
    localparam int WP = 2;
    localparam int AW = 12;
    localparam int DW = 84;
    localparam logic [18:0] RESET_VEC = {3'b111, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcen_n = 1'b1;
    logic        vld = 1'b0;
    logic [10:0] cmd = '0;
    logic        rdy;
    logic [2:0]  cs_n;
    logic        wr_n;
    logic        a0;
    logic [7:0]  d;
    logic        d_oe;
    logic        busy;
    logic [2:0]  level;

    int n_cmp  = 0;
    int n_fail = 0;
    int mode   = 2;
    int div_cnt = 0;

    ikaopll_bus_sequencer #(
        .FIFO_DEPTH(FD), .NUM_CHIPS(NC), .WR_PULSE(WP), .ADDR_WAIT(AW), .DATA_WAIT(DW)
    ) dut (
        .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(pcen_n), .i_CMD_VALID(vld),
        .i_CMD(cmd), .o_CMD_READY(rdy), .o_CS_n(cs_n), .o_WR_n(wr_n), .o_A0(a0),
        .o_D(d), .o_D_OE(d_oe), .o_BUSY(busy), .o_LEVEL(level)
    );

    always #5 clk = ~clk;

    // phiM enable: 0 = EMUCLK/4, 1 = random, 2 = held off, otherwise driven by the test.
    always @(posedge clk) begin
        #1;
        div_cnt++;
        case (mode)
            0: pcen_n = ((div_cnt % 4) != 0);
            1: pcen_n = 1'($urandom_range(0, 1));
            2: pcen_n = 1'b1;
            default: ;
        endcase
    end

    // Reference model: queued commands plus the active command's phiM position.
    logic [10:0] m_q[$];
    logic [10:0] m_cur = '0;
    bit          m_active = 0;
    int          m_pos = 0;
    bit          m_rdy = 0;
    bit          m_push;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_cur = '0;
            m_active = 0;
            m_pos = 0;
            m_rdy = 0;
        end else begin
            m_push = vld && m_rdy;
            if (!pcen_n) begin
                if (m_active) begin
                    m_pos++;
                    if (m_pos == WP + 2 + (m_cur[8] ? DW : AW)) m_active = 0;
                end else if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_active = 1;
                    m_pos = 0;
                end
            end
            if (m_push) m_q.push_back(cmd);
            m_rdy = (m_q.size() != FD);
        end
    end

    function automatic logic [18:0] expv();
        logic [2:0] cs;
        logic       strobe;
        logic       oe;
        cs     = 3'b111;
        strobe = m_active && (m_pos >= 1) && (m_pos <= WP);
        oe     = m_active && (m_pos <= WP + 1);
        if (strobe && (int'(m_cur[10:9]) < NC)) cs[m_cur[10:9]] = 1'b0;
        return {cs, ~strobe, m_cur[8], m_cur[7:0], oe, (m_active || m_q.size() > 0), 3'(m_q.size()), m_rdy};
    endfunction

    function automatic logic [18:0] obs();
        return {cs_n, wr_n, a0, d, d_oe, busy, level, rdy};
    endfunction

    task automatic test_reset();
        mode = 2;
        rst = 1'b1;
        vld = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== RESET_VEC) begin
                n_fail++;
                $display("FAIL reset_values got=%h req=%h", obs(), RESET_VEC);
            end
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_first_edge got=%b req=0", rdy);
        end
        @(negedge clk);
        n_cmp++;
        if (rdy !== 1'b1 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL ready_after_release got=%h req=%h", obs(), expv());
        end
    endtask

    task automatic test_addr_data_pair();
        int falls[$];
        int rises[$];
        int busy_fall = -1000;
        logic prev_cs = 1'b1;
        logic prev_busy = 1'b1;
        mode = 0;
        @(posedge clk); #1 vld = 1'b1; cmd = {2'd0, 1'b0, 8'h10};
        @(posedge clk); #1 cmd = {2'd0, 1'b1, 8'hAC};
        @(posedge clk); #1 vld = 1'b0;
        for (int c = 0; c < 520; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL pair_cycle c=%0d got=%h req=%h", c, obs(), expv());
            end
            if (prev_cs && !cs_n[0]) falls.push_back(c);
            if (!prev_cs && cs_n[0]) rises.push_back(c);
            if (prev_busy && !busy) busy_fall = c;
            prev_cs = cs_n[0];
            prev_busy = busy;
        end
        n_cmp++;
        if (falls.size() != 2 || rises.size() != 2) begin
            n_fail++;
            $display("FAIL pair_strobe_count got=%0d/%0d req=2/2", falls.size(), rises.size());
        end else begin
            n_cmp += 4;
            if (rises[0] - falls[0] != 8) begin
                n_fail++; $display("FAIL addr_cs_width got=%0d req=8", rises[0] - falls[0]);
            end
            if (rises[1] - falls[1] != 8) begin
                n_fail++; $display("FAIL data_cs_width got=%0d req=8", rises[1] - falls[1]);
            end
            if (falls[1] - rises[0] != 60) begin
                n_fail++; $display("FAIL addr_to_data_gap got=%0d req=60", falls[1] - rises[0]);
            end
            if (busy_fall - rises[1] != 340) begin
                n_fail++; $display("FAIL data_wait_busy got=%0d req=340", busy_fall - rises[1]);
            end
        end
    endtask

    task automatic test_queue_full();
        logic [10:0] pushed[5];
        logic [8:0]  caps[$];
        logic        prev_wr = 1'b1;
        mode = 2;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            pushed[i] = {2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 8'($urandom)};
            vld = 1'b1;
            cmd = pushed[i];
        end
        @(posedge clk); #1 vld = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (level !== 3'd4 || rdy !== 1'b0 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL queue_full got=level %0d ready %b req=level 4 ready 0", level, rdy);
        end
        mode = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL full_drain_cycle c=%0d got=%h req=%h", c, obs(), expv());
            end
            if (prev_wr && !wr_n) caps.push_back({a0, d});
            prev_wr = wr_n;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= caps.size() || caps[i] !== pushed[i][8:0]) begin
                n_fail++;
                $display("FAIL full_order idx=%0d got=%h req=%h", i,
                         (i < caps.size()) ? caps[i] : 9'h1FF, pushed[i][8:0]);
            end
        end
        n_cmp++;
        if (caps.size() != 4) begin
            n_fail++;
            $display("FAIL full_write_count got=%0d req=4", caps.size());
        end
    endtask

    task automatic test_multi_chip();
        logic [2:0] cs_req[4] = '{3'b011, 3'b110, 3'b101, 3'b111};
        logic [1:0] chips[4] = '{2'd2, 2'd0, 2'd1, 2'd3};
        logic [2:0] caps[$];
        logic       prev_wr = 1'b1;
        mode = 2;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vld = 1'b1;
            cmd = {chips[i], 1'($urandom_range(0, 1)), 8'($urandom)};
        end
        @(posedge clk); #1 vld = 1'b0;
        mode = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL multi_cycle c=%0d got=%h req=%h", c, obs(), expv());
            end
            if (prev_wr && !wr_n) caps.push_back(cs_n);
            prev_wr = wr_n;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= caps.size() || caps[i] !== cs_req[i]) begin
                n_fail++;
                $display("FAIL multi_cs idx=%0d got=%b req=%b", i,
                         (i < caps.size()) ? caps[i] : 3'bxxx, cs_req[i]);
            end
        end
    endtask

    task automatic test_push_pop_level1();
        mode = 3;
        @(posedge clk); #1 pcen_n = 1'b1; vld = 1'b1; cmd = {2'd0, 1'b0, 8'h5A};
        @(posedge clk); #1 pcen_n = 1'b0; cmd = {2'd1, 1'b1, 8'h33};
        @(posedge clk); #1 pcen_n = 1'b1; vld = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (level !== 3'd1 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL push_pop_level got=%0d req=1", level);
        end
        @(posedge clk); #1 pcen_n = 1'b0;
        @(posedge clk); #1 pcen_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (cs_n !== 3'b110 || wr_n !== 1'b0 || obs() !== expv()) begin
                n_fail++;
                $display("FAIL stall_strobe c=%0d got=cs %b wr %b req=cs 110 wr 0", c, cs_n, wr_n);
            end
        end
        mode = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL stall_drain_cycle c=%0d got=%h req=%h", c, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        mode = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            vld = ($urandom_range(0, 2) == 0);
            cmd = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 8'($urandom)};
            @(negedge clk);
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random_cycle c=%0d got=%h req=%h", c, obs(), expv());
            end
        end
        @(posedge clk); #1 vld = 1'b0;
        mode = 0;
        for (int c = 0; c < 2000 && (m_active || m_q.size() > 0); c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random_drain_cycle c=%0d got=%h req=%h", c, obs(), expv());
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_idle got=%b req=0", busy);
        end
    endtask

    task automatic test_reset_mid_strobe();
        bit seen = 0;
        mode = 3;
        @(posedge clk); #1 pcen_n = 1'b1; vld = 1'b1; cmd = {2'd0, 1'b0, 8'h10};
        @(posedge clk); #1 cmd = {2'd1, 1'b1, 8'h77};
        @(posedge clk); #1 vld = 1'b0; pcen_n = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!wr_n) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (!seen || cs_n !== 3'b110 || d !== 8'h10) begin
            n_fail++;
            $display("FAIL reset_setup_strobe got=cs %b d %h req=cs 110 d 10", cs_n, d);
        end
        rst = 1'b1;
        pcen_n = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cs_n !== 3'b111 || wr_n !== 1'b1 || level !== 3'd0 || busy !== 1'b0 || d_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_strobe got=%h req=%h", obs(), RESET_VEC);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL post_reset_cycle c=%0d got=%h req=%h", c, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_addr_data_pair();
        test_queue_full();
        test_multi_chip();
        test_push_pop_level1();
        test_random();
        test_reset_mid_strobe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
